reg_universal_n: RTL and testbench
==================================

// Module: reg_universal_n
// PURPOSE
//   Parametrised N-bit universal register; successor to the 1-bit load register
//   (REG1) in the storage-element family.
//   Adds per-cycle mode select: hold, parallel load, shift, rotate, increment and
//   decrement, plus a registered carry/borrow/shift-out flag.
//   Building block for the machine's PC, shifter and counter registers.
// PARAMETERS
//   WIDTH      32   register width in bits (>= 2)
//   RESET_VAL  0    value loaded into Q on reset (WIDTH bits)
// PORTS
//   CLK   in   1      clock, all state updates on rising edge
//   RST   in   1      synchronous, active-high reset
//   EN    in   1      operation enable; 0 = hold all state including CO
//   MODE  in   3      operation select (see BEHAVIOUR)
//   D     in   WIDTH  parallel load data
//   SIN   in   1      serial input for shift modes
//   Q     out  WIDTH  register contents
//   QBAR  out  WIDTH  bitwise ~Q (combinational from Q)
//   CO    out  1      registered carry/borrow/shifted-out bit
//   ZERO  out  1      combinational, 1 when Q == 0
// BEHAVIOUR
//   - Reset: RST=1 at a rising CLK edge sets Q=RESET_VAL and CO=0.
//     RST has priority over EN and MODE. Asserting RST mid-sequence discards the operation.
//   - EN=0: Q and CO hold regardless of MODE/D/SIN.
//   - EN=1: each op completes in one cycle; the result is visible the cycle after the edge.
//     - MODE 000 hold:  Q and CO unchanged.
//     - MODE 001 load:  Q<=D; CO<=0.
//     - MODE 010 shl:   Q<={Q[W-2:0],SIN}; CO<=Q[W-1].
//     - MODE 011 shr:   Q<={SIN,Q[W-1:1]}; CO<=Q[0].
//     - MODE 100 rotl:  Q<={Q[W-2:0],Q[W-1]}; CO<=Q[W-1].
//     - MODE 101 rotr:  Q<={Q[0],Q[W-1:1]}; CO<=Q[0].
//     - MODE 110 inc:   Q<=Q+1 mod 2^W; CO<=1 iff old Q was all ones (wraps to 0), else 0.
//     - MODE 111 dec:   Q<=Q-1 mod 2^W; CO<=1 iff old Q was 0 (wraps to all ones), else 0.
//   - Arithmetic is unsigned, WIDTH bits; no saturation.
//   - All right-hand sides use pre-edge Q; no combinational path from D/SIN/MODE to Q.
//   - ZERO and QBAR track Q combinationally, including immediately after reset.
//   - Unknown (X) MODE with EN=1: Q unchanged (treated as hold).
// TESTING
//   1. RST=1, one edge, RESET_VAL=32'h5 -> Q=32'h5, QBAR=~32'h5, CO=0, ZERO=0.
//   2. Load D=32'hFFFF_FFFF, then inc -> Q=0, CO=1, ZERO=1; inc again -> Q=1, CO=0.
//   3. Load 0, dec -> Q=32'hFFFF_FFFF, CO=1; dec -> Q=32'hFFFF_FFFE, CO=0.
//   4. Load 32'h8000_0001:
//      - shl, SIN=0 -> Q=32'h0000_0002, CO=1
//      - rotr      -> Q=32'h0000_0001, CO=0
//      - shr, SIN=1 -> Q=32'h8000_0000, CO=1
//   5. EN=0 with MODE=110 for 3 cycles after Q=7, CO=1 -> Q=7, CO=1 held;
//      then EN=1, MODE=001, D=9 with RST=1 same edge -> Q=RESET_VAL, CO=0.
//   6. WIDTH=4 instance: rotl of 4'b1001 four times -> 0011, 0110, 1100, 1001,
//      with CO = 1, 0, 0, 1.

Source files
------------

// File: rtl/reg_universal_n_if.sv
// Control/data bundle for the N-bit universal register: operation request in,
// register contents and status flags out.
interface reg_universal_n_if #(
  parameter int WIDTH = 32
);
  logic             EN;
  logic [2:0]       MODE;
  logic [WIDTH-1:0] D;
  logic             SIN;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] QBAR;
  logic             CO;
  logic             ZERO;

  modport master (
    output EN, MODE, D, SIN,
    input  Q, QBAR, CO, ZERO
  );

  modport slave (
    input  EN, MODE, D, SIN,
    output Q, QBAR, CO, ZERO
  );
endinterface

// File: rtl/reg_universal_n.sv
// N-bit universal register: hold, load, shift, rotate, increment and decrement
// selected per cycle, with a registered carry/borrow/shift-out flag.
module reg_universal_n #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic               CLK,
  input  logic               RST,
  reg_universal_n_if.slave   bus
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROTL = 3'b100;
  localparam logic [2:0] MODE_ROTR = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

  logic [WIDTH-1:0] r_q;
  logic             r_co;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_co_nxt;

  // Wrapping increment; the extra top bit is the carry out of the all-ones case.
  function automatic logic [WIDTH:0] inc_wrap(input logic [WIDTH-1:0] a);
    inc_wrap = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
  endfunction

  // Wrapping decrement; top bit is the borrow taken when decrementing zero.
  function automatic logic [WIDTH:0] dec_wrap(input logic [WIDTH-1:0] a);
    dec_wrap = {(a == '0), a - {{(WIDTH-1){1'b0}}, 1'b1}};
  endfunction

  always_comb begin
    w_q_nxt  = r_q;
    w_co_nxt = r_co;
    if (bus.EN) begin
      case (bus.MODE)
        MODE_HOLD: begin
          w_q_nxt  = r_q;
          w_co_nxt = r_co;
        end
        MODE_LOAD: begin
          w_q_nxt  = bus.D;
          w_co_nxt = 1'b0;
        end
        MODE_SHL: begin
          w_q_nxt  = {r_q[WIDTH-2:0], bus.SIN};
          w_co_nxt = r_q[WIDTH-1];
        end
        MODE_SHR: begin
          w_q_nxt  = {bus.SIN, r_q[WIDTH-1:1]};
          w_co_nxt = r_q[0];
        end
        MODE_ROTL: begin
          w_q_nxt  = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
          w_co_nxt = r_q[WIDTH-1];
        end
        MODE_ROTR: begin
          w_q_nxt  = {r_q[0], r_q[WIDTH-1:1]};
          w_co_nxt = r_q[0];
        end
        MODE_INC: {w_co_nxt, w_q_nxt} = inc_wrap(r_q);
        MODE_DEC: {w_co_nxt, w_q_nxt} = dec_wrap(r_q);
        // An unresolved mode select leaves the register untouched.
        default: begin
          w_q_nxt  = r_q;
          w_co_nxt = r_co;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q  <= RESET_VAL;
      r_co <= 1'b0;
    end else begin
      r_q  <= w_q_nxt;
      r_co <= w_co_nxt;
    end
  end

  assign bus.Q    = r_q;
  assign bus.QBAR = ~r_q;
  assign bus.CO   = r_co;
  assign bus.ZERO = (r_q == '0);

endmodule

// File: tb/tb_reg_universal_n.sv
// Self-checking bench for reg_universal_n: directed corner cases on a 32-bit and
// a 4-bit instance, then randomized operations against an arithmetic reference.
module tb_reg_universal_n;

  logic clk;
  logic rst32;
  logic rst4;
  int   n_cmp;
  int   n_err;

  logic [31:0] m32_q;
  logic        m32_co;
  logic [31:0] m4_q;
  logic        m4_co;

  reg_universal_n_if #(.WIDTH(32)) if32 ();
  reg_universal_n_if #(.WIDTH(4))  if4 ();

  reg_universal_n #(.WIDTH(32), .RESET_VAL(32'h5)) dut32 (
    .CLK (clk),
    .RST (rst32),
    .bus (if32.slave)
  );

  reg_universal_n #(.WIDTH(4), .RESET_VAL(4'hA)) dut4 (
    .CLK (clk),
    .RST (rst4),
    .bus (if4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: next {CO,Q} for a WIDTH-w register, computed with plain integer math.
  function automatic logic [32:0] ref_next(input int w, input logic [31:0] q,
                                           input logic co, input logic [2:0] mode,
                                           input logic [31:0] d, input logic sin);
    longint unsigned m, qq, nq, nco, s;
    m   = (64'd1 << w) - 64'd1;
    qq  = longint'(q) & m;
    s   = longint'(sin);
    nq  = qq;
    nco = longint'(co);
    case (mode)
      3'd1: begin nq = longint'(d) & m; nco = 0; end
      3'd2: begin nq = ((qq << 1) | s) & m;            nco = (qq >> (w - 1)) & 1; end
      3'd3: begin nq = (qq >> 1) | (s << (w - 1));     nco = qq & 1; end
      3'd4: begin nq = ((qq << 1) | (qq >> (w - 1))) & m; nco = (qq >> (w - 1)) & 1; end
      3'd5: begin nq = (qq >> 1) | ((qq & 1) << (w - 1)); nco = qq & 1; end
      3'd6: begin nq = (qq + 1) % (m + 1);             nco = (qq == m) ? 1 : 0; end
      3'd7: begin nq = (qq + m) % (m + 1);             nco = (qq == 0) ? 1 : 0; end
      default: ;
    endcase
    ref_next = {nco[0], nq[31:0]};
  endfunction

  task automatic step32(input logic rst, input logic en, input logic [2:0] mode,
                        input logic [31:0] d, input logic sin);
    rst32 = rst; if32.EN = en; if32.MODE = mode; if32.D = d; if32.SIN = sin;
    rst4 = 1'b0; if4.EN = 1'b0;
    @(posedge clk);
    #1;
    if (rst) begin
      m32_q = 32'h5; m32_co = 1'b0;
    end else if (en) begin
      {m32_co, m32_q} = ref_next(32, m32_q, m32_co, mode, d, sin);
    end
    rst32 = 1'b0; if32.EN = 1'b0;
  endtask

  task automatic step4(input logic rst, input logic en, input logic [2:0] mode,
                       input logic [3:0] d, input logic sin);
    rst4 = rst; if4.EN = en; if4.MODE = mode; if4.D = d; if4.SIN = sin;
    rst32 = 1'b0; if32.EN = 1'b0;
    @(posedge clk);
    #1;
    if (rst) begin
      m4_q = 32'hA; m4_co = 1'b0;
    end else if (en) begin
      {m4_co, m4_q} = ref_next(4, m4_q, m4_co, mode, {28'd0, d}, sin);
    end
    rst4 = 1'b0; if4.EN = 1'b0;
  endtask

  task automatic test_reset();
    step32(1'b1, 1'b1, 3'b110, 32'h0, 1'b0);
    step4(1'b1, 1'b1, 3'b110, 4'h0, 1'b0);
    n_cmp++; if (if32.Q !== 32'h5) begin n_err++; $display("FAIL reset_q got %h want %h", if32.Q, 32'h5); end
    n_cmp++; if (if32.QBAR !== ~32'h5) begin n_err++; $display("FAIL reset_qbar got %h want %h", if32.QBAR, ~32'h5); end
    n_cmp++; if (if32.CO !== 1'b0) begin n_err++; $display("FAIL reset_co got %b want 0", if32.CO); end
    n_cmp++; if (if32.ZERO !== 1'b0) begin n_err++; $display("FAIL reset_zero got %b want 0", if32.ZERO); end
    n_cmp++; if (if4.Q !== 4'hA) begin n_err++; $display("FAIL reset4_q got %h want a", if4.Q); end
  endtask

  task automatic test_inc_wrap();
    step32(1'b0, 1'b1, 3'b001, 32'hFFFF_FFFF, 1'b0);
    step32(1'b0, 1'b1, 3'b110, 32'h0, 1'b0);
    n_cmp++; if (if32.Q !== 32'h0 || if32.CO !== 1'b1 || if32.ZERO !== 1'b1) begin
      n_err++; $display("FAIL inc_wrap got q=%h co=%b z=%b want q=0 co=1 z=1", if32.Q, if32.CO, if32.ZERO);
    end
    step32(1'b0, 1'b1, 3'b110, 32'h0, 1'b0);
    n_cmp++; if (if32.Q !== 32'h1 || if32.CO !== 1'b0 || if32.ZERO !== 1'b0) begin
      n_err++; $display("FAIL inc_after_wrap got q=%h co=%b z=%b want q=1 co=0 z=0", if32.Q, if32.CO, if32.ZERO);
    end
  endtask

  task automatic test_dec_wrap();
    step32(1'b0, 1'b1, 3'b001, 32'h0, 1'b0);
    n_cmp++; if (if32.ZERO !== 1'b1 || if32.QBAR !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL load_zero got z=%b qbar=%h want z=1 qbar=ffffffff", if32.ZERO, if32.QBAR);
    end
    step32(1'b0, 1'b1, 3'b111, 32'h0, 1'b0);
    n_cmp++; if (if32.Q !== 32'hFFFF_FFFF || if32.CO !== 1'b1) begin
      n_err++; $display("FAIL dec_wrap got q=%h co=%b want q=ffffffff co=1", if32.Q, if32.CO);
    end
    step32(1'b0, 1'b1, 3'b111, 32'h0, 1'b0);
    n_cmp++; if (if32.Q !== 32'hFFFF_FFFE || if32.CO !== 1'b0) begin
      n_err++; $display("FAIL dec_after_wrap got q=%h co=%b want q=fffffffe co=0", if32.Q, if32.CO);
    end
  endtask

  task automatic test_shift_rotate();
    step32(1'b0, 1'b1, 3'b001, 32'h8000_0001, 1'b1);
    step32(1'b0, 1'b1, 3'b010, 32'h0, 1'b0);
    n_cmp++; if (if32.Q !== 32'h0000_0002 || if32.CO !== 1'b1) begin
      n_err++; $display("FAIL shl got q=%h co=%b want q=00000002 co=1", if32.Q, if32.CO);
    end
    step32(1'b0, 1'b1, 3'b101, 32'h0, 1'b1);
    n_cmp++; if (if32.Q !== 32'h0000_0001 || if32.CO !== 1'b0) begin
      n_err++; $display("FAIL rotr got q=%h co=%b want q=00000001 co=0", if32.Q, if32.CO);
    end
    step32(1'b0, 1'b1, 3'b011, 32'h0, 1'b1);
    n_cmp++; if (if32.Q !== 32'h8000_0000 || if32.CO !== 1'b1) begin
      n_err++; $display("FAIL shr got q=%h co=%b want q=80000000 co=1", if32.Q, if32.CO);
    end
    step32(1'b0, 1'b1, 3'b000, 32'h1234_5678, 1'b0);
    n_cmp++; if (if32.Q !== 32'h8000_0000 || if32.CO !== 1'b1) begin
      n_err++; $display("FAIL mode_hold got q=%h co=%b want q=80000000 co=1", if32.Q, if32.CO);
    end
  endtask

  task automatic test_enable_hold();
    step32(1'b0, 1'b1, 3'b001, 32'h8000_0003, 1'b0);
    step32(1'b0, 1'b1, 3'b010, 32'h0, 1'b1);
    n_cmp++; if (if32.Q !== 32'h7 || if32.CO !== 1'b1) begin
      n_err++; $display("FAIL setup_q7 got q=%h co=%b want q=7 co=1", if32.Q, if32.CO);
    end
    for (int i = 0; i < 3; i++) begin
      step32(1'b0, 1'b0, 3'b110, 32'hDEAD_BEEF, 1'b1);
      n_cmp++; if (if32.Q !== 32'h7 || if32.CO !== 1'b1) begin
        n_err++; $display("FAIL en_hold[%0d] got q=%h co=%b want q=7 co=1", i, if32.Q, if32.CO);
      end
    end
    step32(1'b1, 1'b1, 3'b001, 32'h9, 1'b0);
    n_cmp++; if (if32.Q !== 32'h5 || if32.CO !== 1'b0) begin
      n_err++; $display("FAIL rst_priority got q=%h co=%b want q=5 co=0", if32.Q, if32.CO);
    end
  endtask

  task automatic test_width4_rotl();
    logic [3:0] exp_q  [4];
    logic       exp_co [4];
    exp_q  = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};
    exp_co = '{1'b1, 1'b0, 1'b0, 1'b1};
    step4(1'b0, 1'b1, 3'b001, 4'b1001, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step4(1'b0, 1'b1, 3'b100, 4'b0000, 1'b0);
      n_cmp++; if (if4.Q !== exp_q[i] || if4.CO !== exp_co[i]) begin
        n_err++; $display("FAIL rotl4[%0d] got q=%b co=%b want q=%b co=%b", i, if4.Q, if4.CO, exp_q[i], exp_co[i]);
      end
    end
  endtask

  task automatic test_random();
    logic        r, e, s;
    logic [2:0]  md;
    logic [31:0] dv;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 31) == 0);
      e  = ($urandom_range(0, 3) != 0);
      md = 3'($urandom_range(0, 7));
      s  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       dv = 32'h0;
        1:       dv = 32'hFFFF_FFFF;
        default: dv = $urandom;
      endcase
      if (i[0]) begin
        step4(r, e, md, dv[3:0], s);
        n_cmp++; if (if4.Q !== m4_q[3:0] || if4.CO !== m4_co || if4.QBAR !== ~m4_q[3:0] ||
                     if4.ZERO !== (m4_q[3:0] == 4'h0)) begin
          n_err++; $display("FAIL rand4[%0d] mode=%0d got q=%h co=%b want q=%h co=%b", i, md, if4.Q, if4.CO, m4_q[3:0], m4_co);
        end
      end else begin
        step32(r, e, md, dv, s);
        n_cmp++; if (if32.Q !== m32_q || if32.CO !== m32_co || if32.QBAR !== ~m32_q ||
                     if32.ZERO !== (m32_q == 32'h0)) begin
          n_err++; $display("FAIL rand32[%0d] mode=%0d got q=%h co=%b want q=%h co=%b", i, md, if32.Q, if32.CO, m32_q, m32_co);
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst32 = 1'b0; rst4 = 1'b0;
    if32.EN = 1'b0; if32.MODE = 3'b000; if32.D = '0; if32.SIN = 1'b0;
    if4.EN  = 1'b0; if4.MODE  = 3'b000; if4.D  = '0; if4.SIN  = 1'b0;
    m32_q = 32'h0; m32_co = 1'b0; m4_q = 32'h0; m4_co = 1'b0;
    #2;
    test_reset();
    test_inc_wrap();
    test_dec_wrap();
    test_shift_rotate();
    test_enable_hold();
    test_width4_rotl();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
